// File: rtl/sd_digit_append_pkg.sv
// Shared definitions for the signed-digit append front end: FSM state codes
// and the two-bit redundant digit encodings.
package sd_digit_append_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_INIT  = 2'b01,
        ST_ACCUM = 2'b11,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [1:0] SD_POS  = 2'b10;
    localparam logic [1:0] SD_NEG  = 2'b01;
    localparam logic [1:0] SD_ZERO = 2'b00;
    localparam logic [1:0] SD_ILL  = 2'b11;

endpackage

// File: rtl/sd_append_ctrl.sv
// Control for the digit append stage: FSM, digit counter, handshake and done
// generation, plus the one-hot write position of the next digit (MSB first).
module sd_append_ctrl
    import sd_digit_append_pkg::*;
#(
    parameter  int Num_bits = 4,
    localparam int CNT_W    = $clog2(Num_bits + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_digit_valid,
    output logic                o_digit_ready,
    output logic                o_accept,
    output logic                o_init,
    output state_t              o_state,
    output logic [CNT_W-1:0]    o_digit_cnt,
    output logic                o_done,
    output logic [Num_bits-1:0] o_pos
);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_last;

    assign o_digit_ready = (r_state == ST_ACCUM);
    assign o_accept      = o_digit_ready && i_digit_valid;
    assign o_init        = (r_state == ST_INIT);
    assign o_done        = (r_state == ST_DONE);
    assign o_state       = r_state;
    assign o_digit_cnt   = r_cnt;
    assign w_last        = (r_cnt == CNT_W'(Num_bits - 1));

    // NOTE: every always_comb output gets a default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_next = ST_INIT;
            ST_INIT:  w_next = ST_ACCUM;
            ST_ACCUM: if (o_accept && w_last) w_next = ST_DONE;
            ST_DONE:  w_next = i_start ? ST_INIT : ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Digit j lands at bit Num_bits-1-j.
    always_comb begin
        o_pos = '0;
        for (int i = 0; i < Num_bits; i++) begin
            if (r_cnt == CNT_W'(Num_bits - 1 - i)) o_pos[i] = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (o_init)
                r_cnt <= '0;
            else if (o_accept)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sd_digit_append.sv
// On-line operand prefix builder: appends each accepted signed digit into a
// plus/minus vector pair and forwards it as a registered two-bit select.
module sd_digit_append
    import sd_digit_append_pkg::*;
#(
    parameter  int Num_bits = 4,
    localparam int CNT_W    = $clog2(Num_bits + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                digit_valid,
    input  logic [1:0]          digit_in,
    output logic                digit_ready,
    output logic [Num_bits-1:0] vec_out_plus,
    output logic [Num_bits-1:0] vec_out_minus,
    output logic [1:0]          digit_select,
    output logic [1:0]          STATE,
    output logic [CNT_W-1:0]    digit_cnt,
    output logic                done,
    output logic                digit_err
);

    logic                w_accept;
    logic                w_init;
    state_t              w_state;
    logic [Num_bits-1:0] w_pos;
    logic [Num_bits-1:0] r_plus;
    logic [Num_bits-1:0] r_minus;
    logic [1:0]          r_sel;
    logic                r_err;

    sd_append_ctrl #(.Num_bits(Num_bits)) u_ctrl (
        .clk           (clk),
        .rst           (rst),
        .i_start       (start),
        .i_digit_valid (digit_valid),
        .o_digit_ready (digit_ready),
        .o_accept      (w_accept),
        .o_init        (w_init),
        .o_state       (w_state),
        .o_digit_cnt   (digit_cnt),
        .o_done        (done),
        .o_pos         (w_pos)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_plus  <= '0;
            r_minus <= '0;
            r_sel   <= SD_ZERO;
            r_err   <= 1'b0;
        end else begin
            // Bubble or non-transfer cycles forward a zero digit downstream.
            r_sel <= SD_ZERO;
            if (w_init) begin
                r_plus  <= '0;
                r_minus <= '0;
                r_err   <= 1'b0;
            end else if (w_accept) begin
                case (digit_in)
                    SD_POS:  begin r_plus  <= r_plus  | w_pos; r_sel <= SD_POS; end
                    SD_NEG:  begin r_minus <= r_minus | w_pos; r_sel <= SD_NEG; end
                    SD_ILL:  r_err <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign vec_out_plus  = r_plus;
    assign vec_out_minus = r_minus;
    assign digit_select  = r_sel;
    assign digit_err     = r_err;
    assign STATE         = w_state;

endmodule

// File: tb/tb_sd_digit_append.sv
// Self-checking bench for sd_digit_append: a reference model pushes the
// expected post-edge outputs to a scoreboard, popped and compared after the edge.
module tb_sd_digit_append;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         digit_valid = 1'b0;
    logic [1:0]   digit_in = 2'b00;
    logic         digit_ready;
    logic [N-1:0] vec_out_plus;
    logic [N-1:0] vec_out_minus;
    logic [1:0]   digit_select;
    logic [1:0]   STATE;
    logic [2:0]   digit_cnt;
    logic         done;
    logic         digit_err;

    sd_digit_append #(.Num_bits(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .digit_valid   (digit_valid),
        .digit_in      (digit_in),
        .digit_ready   (digit_ready),
        .vec_out_plus  (vec_out_plus),
        .vec_out_minus (vec_out_minus),
        .digit_select  (digit_select),
        .STATE         (STATE),
        .digit_cnt     (digit_cnt),
        .done          (done),
        .digit_err     (digit_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]   st;
        logic [1:0]   sel;
        logic [N-1:0] p;
        logic [N-1:0] m;
        logic [2:0]   cnt;
        logic         dn;
        logic         err;
        logic         rdy;
    } obs_t;

    obs_t sb_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    // Reference model state
    logic [1:0]   m_state = 2'b00;
    logic [N-1:0] m_p     = '0;
    logic [N-1:0] m_m     = '0;
    int           m_cnt   = 0;
    logic         m_err   = 1'b0;

    function automatic obs_t sample();
        obs_t o;
        o.st  = STATE;
        o.sel = digit_select;
        o.p   = vec_out_plus;
        o.m   = vec_out_minus;
        o.cnt = digit_cnt;
        o.dn  = done;
        o.err = digit_err;
        o.rdy = digit_ready;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.st  = m_state;
        o.sel = 2'b00;
        o.p   = m_p;
        o.m   = m_m;
        o.cnt = 3'(m_cnt);
        o.dn  = (m_state == 2'b10);
        o.err = m_err;
        o.rdy = (m_state == 2'b11);
        return o;
    endfunction

    task automatic model_reset();
        m_state = 2'b00; m_p = '0; m_m = '0; m_cnt = 0; m_err = 1'b0;
        sb_q.delete();
    endtask

    task automatic check_obs(input string tag, input obs_t exp_v);
        obs_t got;
        got = sample();
        n_total++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got st=%b sel=%b p=%b m=%b cnt=%0d done=%b err=%b rdy=%b, want st=%b sel=%b p=%b m=%b cnt=%0d done=%b err=%b rdy=%b",
                     tag, got.st, got.sel, got.p, got.m, got.cnt, got.dn, got.err, got.rdy,
                     exp_v.st, exp_v.sel, exp_v.p, exp_v.m, exp_v.cnt, exp_v.dn, exp_v.err, exp_v.rdy);
        end
    endtask

    // One clock: predict, push, drive, clock, pop and compare.
    task automatic step(input logic st, input logic v, input logic [1:0] d, input string tag);
        obs_t       e;
        logic       acc;
        logic [1:0] ns;
        acc = (m_state == 2'b11) && v;
        ns  = m_state;
        case (m_state)
            2'b00: if (st) ns = 2'b01;
            2'b01: ns = 2'b11;
            2'b11: if (acc && m_cnt == N - 1) ns = 2'b10;
            2'b10: ns = st ? 2'b01 : 2'b00;
            default: ns = 2'b00;
        endcase
        if (m_state == 2'b01) begin
            m_p = '0; m_m = '0; m_cnt = 0; m_err = 1'b0;
        end else if (acc) begin
            if (d == 2'b10) m_p[N-1-m_cnt] = 1'b1;
            if (d == 2'b01) m_m[N-1-m_cnt] = 1'b1;
            if (d == 2'b11) m_err = 1'b1;
            m_cnt++;
        end
        m_state = ns;
        e = model_obs();
        e.sel = (acc && d != 2'b11) ? d : 2'b00;
        sb_q.push_back(e);

        start = st; digit_valid = v; digit_in = d;
        @(posedge clk); #1;
        start = 1'b0; digit_valid = 1'b0; digit_in = 2'b00;
        e = sb_q.pop_front();
        check_obs(tag, e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%b want=%b", tag, got, want);
        end
    endtask

    task automatic test_reset();
        obs_t z;
        z = '0;
        #3;
        check_obs("reset_hold", z);
        rst = 1'b0;
        model_reset();
        step(1'b0, 1'b0, 2'b00, "idle_after_reset");
        step(1'b1, 1'b0, 2'b00, "rst_start");
        step(1'b0, 1'b0, 2'b00, "rst_init");
        step(1'b0, 1'b1, 2'b10, "rst_d0");
        step(1'b0, 1'b1, 2'b01, "rst_d1");
        // Asynchronous reset mid-operand, observed before the next edge.
        #1 rst = 1'b1;
        #1 check_obs("reset_async_accum", z);
        #1 rst = 1'b0;
        model_reset();
        step(1'b0, 1'b1, 2'b10, "after_async_reset_idle");
    endtask

    task automatic test_basic();
        logic [1:0] sel_seq [4];
        logic [1:0] st_seq  [8];
        logic [1:0] d_seq   [4];
        d_seq = '{2'b10, 2'b01, 2'b00, 2'b10};
        st_seq[0] = STATE;
        step(1'b1, 1'b0, 2'b00, "basic_start");
        st_seq[1] = STATE;
        step(1'b0, 1'b0, 2'b00, "basic_init");
        st_seq[2] = STATE;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, d_seq[i], $sformatf("basic_d%0d", i));
            sel_seq[i]   = digit_select;
            st_seq[3+i]  = STATE;
            if (i == 3) check_val("basic_done_pulse", {7'd0, done}, 8'd1);
        end
        check_val("basic_plus",  {4'd0, vec_out_plus},  8'b0000_1001);
        check_val("basic_minus", {4'd0, vec_out_minus}, 8'b0000_0100);
        step(1'b0, 1'b0, 2'b00, "basic_back_idle");
        st_seq[7] = STATE;
        check_val("basic_done_drop", {7'd0, done}, 8'd0);
        check_val("basic_sel_seq", {sel_seq[0], sel_seq[1], sel_seq[2], sel_seq[3]}, 8'b10_01_00_10);
        check_val("basic_st_seq_a", {st_seq[0], st_seq[1], st_seq[2], st_seq[3]}, 8'b00_01_11_11);
        check_val("basic_st_seq_b", {st_seq[4], st_seq[5], st_seq[6], st_seq[7]}, 8'b11_11_10_00);
        check_val("idle_holds_cnt", {5'd0, digit_cnt}, 8'd4);
    endtask

    task automatic test_stall();
        step(1'b1, 1'b0, 2'b00, "stall_start");
        step(1'b0, 1'b0, 2'b00, "stall_init");
        step(1'b0, 1'b1, 2'b10, "stall_d0");
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 2'b01, $sformatf("stall_bubble%0d", i));
            check_val("stall_bubble_sel", {6'd0, digit_select}, 8'd0);
            check_val("stall_bubble_cnt", {5'd0, digit_cnt}, 8'd1);
        end
        step(1'b0, 1'b1, 2'b01, "stall_d1");
        step(1'b0, 1'b1, 2'b01, "stall_d2");
        step(1'b0, 1'b1, 2'b10, "stall_d3");
        check_val("stall_plus",  {4'd0, vec_out_plus},  8'b0000_1001);
        check_val("stall_minus", {4'd0, vec_out_minus}, 8'b0000_0110);
        step(1'b0, 1'b0, 2'b00, "stall_idle");
    endtask

    task automatic test_illegal();
        step(1'b1, 1'b0, 2'b00, "ill_start");
        step(1'b0, 1'b0, 2'b00, "ill_init");
        step(1'b0, 1'b1, 2'b10, "ill_d0");
        step(1'b0, 1'b1, 2'b11, "ill_d1");
        check_val("ill_err_set", {7'd0, digit_err}, 8'd1);
        step(1'b0, 1'b1, 2'b01, "ill_d2");
        step(1'b0, 1'b1, 2'b00, "ill_d3");
        check_val("ill_cnt", {5'd0, digit_cnt}, 8'd4);
        check_val("ill_bit2", {6'd0, vec_out_plus[2], vec_out_minus[2]}, 8'd0);
        step(1'b0, 1'b0, 2'b00, "ill_idle");
        check_val("ill_err_sticky", {7'd0, digit_err}, 8'd1);
        step(1'b1, 1'b0, 2'b00, "ill_restart");
        step(1'b0, 1'b0, 2'b00, "ill_reinit");
        check_val("ill_err_cleared", {7'd0, digit_err}, 8'd0);
    endtask

    task automatic test_start_in_accum();
        // Continues from ACCUM left by test_illegal.
        step(1'b1, 1'b1, 2'b10, "accum_start_d0");
        step(1'b1, 1'b0, 2'b00, "accum_start_idle");
        check_val("accum_start_state", {6'd0, STATE}, 8'b0000_0011);
        step(1'b1, 1'b1, 2'b01, "accum_start_d1");
        step(1'b0, 1'b1, 2'b10, "accum_start_d2");
        step(1'b0, 1'b1, 2'b01, "accum_start_d3");
    endtask

    task automatic test_back_to_back();
        // DONE with start held goes straight to INIT.
        step(1'b1, 1'b0, 2'b00, "b2b_done_to_init");
        check_val("b2b_init_state", {6'd0, STATE}, 8'b0000_0001);
        step(1'b1, 1'b0, 2'b00, "b2b_init");
        check_val("b2b_vec_cleared", {vec_out_plus, vec_out_minus}, 8'd0);
        for (int i = 0; i < N; i++) step(1'b0, 1'b1, 2'b01, $sformatf("b2b_d%0d", i));
        check_val("b2b_minus_all", {4'd0, vec_out_minus}, 8'b0000_1111);
        step(1'b0, 1'b0, 2'b00, "b2b_idle");
    endtask

    task automatic test_start_with_valid();
        do_reset();
        step(1'b1, 1'b1, 2'b10, "sv_start_valid");
        check_val("sv_sel_dropped", {6'd0, digit_select}, 8'd0);
        step(1'b0, 1'b0, 2'b00, "sv_init");
        check_val("sv_vec_zero", {vec_out_plus, vec_out_minus}, 8'd0);
        check_val("sv_cnt_zero", {5'd0, digit_cnt}, 8'd0);
        step(1'b0, 1'b1, 2'b10, "sv_d0");
    endtask

    initial begin
        test_reset();
        do_reset();
        test_basic();
        test_stall();
        test_illegal();
        test_start_in_accum();
        test_back_to_back();
        test_start_with_valid();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/sd_digit_append.md
Name: sd_digit_append

Overview:
- Upstream feeder for the signed-digit vector multiplier stage in the online multiplier datapath.
- Accepts one redundant signed digit per cycle, MSB first, over a valid handshake.
- Builds the on-line operand prefix as a plus/minus vector pair by appending each digit at its position.
- Forwards the current digit in the two-bit select encoding and drives the 2-bit STATE bus consumed downstream.

Parameters:
Num_bits, 4, operand length in digits; width of the plus/minus vectors.
CNT_W, $clog2(Num_bits+1), digit counter width (derived; not overridden).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
start  input  1  begin a new operand; honoured in IDLE and DONE only
digit_valid  input  1  digit_in carries a digit this cycle
digit_in  input  2  signed digit: 2'b10=+1, 2'b01=-1, 2'b00=0, 2'b11=illegal
digit_ready  output  1  high in ACCUM only; a digit transfers when digit_valid && digit_ready
vec_out_plus  output  Num_bits  positive-digit vector of accepted prefix
vec_out_minus  output  Num_bits  negative-digit vector of accepted prefix
digit_select  output  2  registered copy of the digit accepted on the last edge, else 2'b00
STATE  output  2  FSM state code for downstream stages
digit_cnt  output  CNT_W  number of digits accepted so far
done  output  1  one-cycle pulse: operand complete
digit_err  output  1  sticky: illegal digit seen since last start

Behaviour:
- Reset (async, rst=1):
  - vec_out_plus = 0 and vec_out_minus = 0.
  - digit_select = 2'b00, digit_cnt = 0, done = 0, digit_err = 0.
  - STATE = IDLE.
  - Reset asserted mid-operand discards the operand immediately.
- FSM encoding: IDLE=2'b00, INIT=2'b01, ACCUM=2'b11, DONE=2'b10.
  - IDLE: start -> INIT.
  - INIT, one cycle only:
    - clears both vectors, digit_cnt and digit_err;
    - digit_select = 00;
    - -> ACCUM.
  - ACCUM:
    - each transfer writes digit j = digit_cnt into bit index Num_bits-1-j;
    - +1 sets the plus bit; -1 sets the minus bit; 0 sets neither;
    - digit_cnt increments;
    - the transfer that brings digit_cnt to Num_bits -> DONE.
  - DONE, one cycle:
    - done=1; vectors and digit_cnt hold;
    - start -> INIT, otherwise -> IDLE.
  - IDLE holds vectors and digit_cnt from the last operand until the next INIT.
- Timing:
  - Vectors, digit_cnt and digit_select update on the same edge that accepts the digit.
  - The consumer sees prefix X[j] together with digit j in the cycle after the transfer.
  - Latency from transfer to outputs = 1 cycle.
- Stall:
  - digit_valid=0 in ACCUM holds vectors and digit_cnt.
  - digit_select = 00 on the next cycle (bubble), so the downstream partial product is zero.
- Illegal digit 2'b11:
  - accepted and counted as 0; no vector bit is set; digit_select = 00;
  - digit_err set, and held until the next INIT.
- Ignored inputs:
  - digit_valid outside ACCUM: digit_select stays 00.
  - start while in INIT or ACCUM.
- Simultaneous start and digit_valid in IDLE or DONE: start wins and the digit is dropped (digit_ready=0).
- Vector bits are only ever set, never cleared, within an operand. plus&minus is never 1 at any bit.
- digit_cnt never exceeds Num_bits; no wrap-around occurs.

Decomposition:
- Shared package:
  - STATE codes IDLE/INIT/ACCUM/DONE;
  - digit encodings SD_POS=2'b10, SD_NEG=2'b01, SD_ZERO=2'b00.
- Natural sub-module: sd_append_ctrl, containing the FSM, digit_cnt, ready/done generation and the position one-hot decode.
- The vector registers and digit_select register stay in the top module.

Test Plan:
- Reset during ACCUM after 2 digits -> all outputs zero and STATE=00 asynchronously, before the next clk edge.
- Num_bits=4; start, then digits +1,-1,0,+1 back-to-back:
  - vec_out_plus=4'b1001, vec_out_minus=4'b0100;
  - digit_select sequence 10,01,00,10;
  - done pulses the cycle after the 4th transfer; STATE sequence 00,01,11,11,11,11,10,00.
- Stall: send +1, drop valid for 2 cycles, then -1,-1,+1:
  - digit_select=00 during the bubbles; digit_cnt holds at 1;
  - final vec_out_plus=1001, vec_out_minus=0110.
- Illegal 2'b11 as the second digit:
  - digit_err=1 and remains set; digit_cnt still reaches 4;
  - bit 2 is 0 in both vectors;
  - a new start clears digit_err in INIT.
- start asserted in ACCUM -> ignored.
- start held through DONE -> DONE to INIT directly; vectors cleared in INIT.
- start together with digit_valid in IDLE -> digit dropped, vectors stay 0, digit_cnt=0 after INIT.
